// File: rtl/working_zone_batch.sv
// Batch working-zone encoder: loads zone bases, count N and N addresses
// from a single-port RAM, encodes each one and writes results back.
// Ports: i_clk/i_rst (async, active-high), i_start level request,
//   i_data RAM read data (1-cycle latency); o_address/o_en/o_we/o_data
//   drive the RAM; o_done flags a finished batch until i_start drops.
module working_zone_batch #(
  parameter int DATA_W   = 8,
  parameter int NUM_WZ   = 8,
  parameter int WZ_SIZE  = 4,
  parameter int MEM_AW   = 16,
  parameter int RES_BASE = 512
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  output logic [MEM_AW-1:0] o_address,
  output logic              o_en,
  output logic              o_we,
  output logic [DATA_W-1:0] o_data,
  output logic              o_done
);

  localparam int ZW = $clog2(NUM_WZ);
  localparam int JW = $clog2(NUM_WZ + 1);
  localparam int EW = DATA_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CFG,
    S_CFG_WAIT,
    S_RD_ADDR,
    S_CAP_ADDR,
    S_WR,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [JW-1:0]     j_q, j_d;
  logic [JW-1:0]     j_prev;
  logic [DATA_W-1:0] k_q, k_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] base_q [NUM_WZ];
  logic [DATA_W-1:0] base_d [NUM_WZ];

  logic               hit;
  logic [ZW-1:0]      hit_z;
  logic [DATA_W-1:0]  hit_off;
  logic [WZ_SIZE-1:0] onehot;
  logic [DATA_W-1:0]  enc;

  // Read data lags the issued address by one cycle.
  assign j_prev = j_q - 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      for (int i = 0; i < NUM_WZ; i++) begin
        base_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      for (int i = 0; i < NUM_WZ; i++) begin
        base_q[i] <= base_d[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    for (int i = 0; i < NUM_WZ; i++) begin
      base_d[i] = base_q[i];
    end
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_RD_CFG;
          j_d     = '0;
        end
      end
      S_RD_CFG: begin
        if (j_q != '0) begin
          base_d[j_prev[ZW-1:0]] = i_data;
        end
        j_d = j_q + 1'b1;
        if (j_q == JW'(NUM_WZ)) begin
          state_d = S_CFG_WAIT;
        end
      end
      S_CFG_WAIT: begin
        cnt_d   = i_data;
        k_d     = '0;
        state_d = (i_data == '0) ? S_DONE : S_RD_ADDR;
      end
      S_RD_ADDR: begin
        state_d = S_CAP_ADDR;
      end
      S_CAP_ADDR: begin
        addr_d  = i_data;
        state_d = S_WR;
      end
      S_WR: begin
        if (k_q == cnt_q - 1'b1) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = S_RD_ADDR;
        end
      end
      S_DONE: begin
        if (!i_start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Descending scan so the lowest hitting zone wins.
  // Extra top bit keeps base+WZ_SIZE-1 from wrapping.
  always_comb begin
    hit     = 1'b0;
    hit_z   = '0;
    hit_off = '0;
    for (int z = NUM_WZ - 1; z >= 0; z--) begin
      if (({1'b0, addr_q} >= {1'b0, base_q[z]}) &&
          ({1'b0, addr_q} <=
           {1'b0, base_q[z]} + EW'(WZ_SIZE - 1))) begin
        hit     = 1'b1;
        hit_z   = ZW'(z);
        hit_off = addr_q - base_q[z];
      end
    end
  end

  assign onehot = WZ_SIZE'(1) << hit_off;
  assign enc    = hit ? {1'b1, hit_z, onehot} : addr_q;

  // Outputs depend only on registered state.
  always_comb begin
    o_address = '0;
    o_en      = 1'b0;
    o_we      = 1'b0;
    o_data    = '0;
    o_done    = 1'b0;
    unique case (state_q)
      S_RD_CFG: begin
        o_en      = 1'b1;
        o_address = MEM_AW'(j_q);
      end
      S_RD_ADDR: begin
        o_en      = 1'b1;
        o_address = MEM_AW'(NUM_WZ + 1) + MEM_AW'(k_q);
      end
      S_WR: begin
        o_en      = 1'b1;
        o_we      = 1'b1;
        o_address = MEM_AW'(RES_BASE) + MEM_AW'(k_q);
        o_data    = enc;
      end
      S_DONE: begin
        o_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_working_zone_batch.sv
// Directed bench for working_zone_batch with a behavioural 1-cycle RAM.
// Vector table plus hand sequences for start-hold and mid-batch reset.
module tb_working_zone_batch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rdata;
  logic [15:0] o_address;
  logic        o_en;
  logic        o_we;
  logic [7:0]  o_data;
  logic        o_done;

  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [7:0]  ld_data;
  logic [7:0]  mem [0:1023];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int e0 = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];

  typedef struct {
    logic [7:0][7:0] bases;
    int              n;
    logic [3:0][7:0] addrs;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t vecs[6];

  localparam logic [7:0][7:0] B_STD =
    {8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd0};

  always #5 clk = ~clk;

  working_zone_batch dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_data(rdata),
    .o_address(o_address),
    .o_en(o_en),
    .o_we(o_we),
    .o_data(o_data),
    .o_done(o_done)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld_en) begin
      mem[ld_addr] = ld_data;
    end else if (o_en) begin
      if (o_we) mem[o_address[9:0]] = o_data;
      else rdata <= mem[o_address[9:0]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("we_without_en", 32'(o_we && !o_en), 0);
      chk("data_when_no_we", 32'(!o_we && o_data != 0), 0);
    end
  end

  task automatic poke(input int a, input logic [7:0] d);
    ld_en   = 1'b1;
    ld_addr = 10'(a);
    ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < 8; i++) poke(i, v.bases[i]);
    poke(8, 8'(v.n));
    for (int i = 0; i < 4; i++) poke(9 + i, v.addrs[i]);
    for (int i = 0; i < 8; i++) poke(512 + i, 8'hEE);
  endtask

  task automatic run_batch(input int budget, output int done_rel);
    int rel;
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    start = 1'b1;
    e0 = cyc + 1;
    done_rel = -1;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      rel = cyc - e0 + 1;
      if (o_en && o_we) begin
        wr_addr.push_back(int'(o_address));
        wr_data.push_back(int'(o_data));
        wr_cyc.push_back(rel);
      end
      if (o_done) begin
        done_rel = rel;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int drop);
    int d;
    load(v);
    run_batch(200, d);
    chk("done_cycle", 32'(d), 32'(11 + 3 * v.n));
    chk("num_writes", 32'(wr_addr.size()), 32'(v.n));
    for (int k = 0; k < v.n && k < wr_addr.size(); k++) begin
      chk("wr_addr", 32'(wr_addr[k]), 32'(512 + k));
      chk("wr_data", 32'(wr_data[k]), 32'(v.exp[k]));
      chk("wr_cycle", 32'(wr_cyc[k]), 32'(13 + 3 * k));
      chk("mem_result", 32'(mem[512 + k]), 32'(v.exp[k]));
    end
    chk("no_extra_write", 32'(mem[512 + v.n]), 32'hEE);
    if (drop != 0) begin
      start = 1'b0;
      @(negedge clk);
      chk("done_low_idle", 32'(o_done), 0);
    end
  endtask

  initial begin
    int rel;
    rst   = 1'b1;
    start = 1'b0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;

    vecs[0].bases = B_STD;
    vecs[0].n     = 1;
    vecs[0].addrs = {8'd0, 8'd0, 8'd0, 8'd42};
    vecs[0].exp   = {8'h00, 8'h00, 8'h00, 8'hC4};
    vecs[1].bases = B_STD;
    vecs[1].n     = 3;
    vecs[1].addrs = {8'd0, 8'd77, 8'd9, 8'd33};
    vecs[1].exp   = {8'h00, 8'h4D, 8'h09, 8'hB8};
    vecs[2].bases = {8'd150, 8'd140, 8'd130, 8'd120,
                     8'd110, 8'd100, 8'd4, 8'd5};
    vecs[2].n     = 2;
    vecs[2].addrs = {8'd0, 8'd0, 8'd4, 8'd6};
    vecs[2].exp   = {8'h00, 8'h00, 8'h91, 8'h82};
    vecs[3].bases = {8'd254, 8'd160, 8'd150, 8'd140,
                     8'd130, 8'd120, 8'd110, 8'd100};
    vecs[3].n     = 4;
    vecs[3].addrs = {8'd253, 8'd254, 8'd1, 8'd255};
    vecs[3].exp   = {8'hFD, 8'hF1, 8'h01, 8'hF2};
    vecs[4].bases = B_STD;
    vecs[4].n     = 0;
    vecs[4].addrs = '0;
    vecs[4].exp   = '0;
    vecs[5].bases = B_STD;
    vecs[5].n     = 3;
    vecs[5].addrs = {8'd0, 8'd10, 8'd3, 8'd73};
    vecs[5].exp   = {8'h00, 8'h91, 8'h88, 8'hF8};

    repeat (2) @(negedge clk);
    chk("rst_address", 32'(o_address), 0);
    chk("rst_en", 32'(o_en), 0);
    chk("rst_we", 32'(o_we), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_done", 32'(o_done), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      run_vec(vecs[v], 1);
    end

    // N=0 with start held: DONE persists, no new reads.
    run_vec(vecs[4], 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_no_read", 32'(o_en), 0);
      chk("hold_done", 32'(o_done), 1);
    end
    start = 1'b0;
    @(negedge clk);
    chk("drop_done", 32'(o_done), 0);
    chk("drop_en", 32'(o_en), 0);
    run_vec(vecs[0], 1);

    // Reset during the second write of an N=3 batch.
    load(vecs[1]);
    start = 1'b1;
    e0 = cyc + 1;
    rel = 0;
    for (int t = 0; t < 100 && rel != 16; t++) begin
      @(negedge clk);
      rel = cyc - e0 + 1;
    end
    chk("wr2_reached", 32'(rel), 16);
    chk("wr2_we", 32'(o_we), 1);
    chk("wr2_addr", 32'(o_address), 513);
    #1 rst = 1'b1;
    #1;
    chk("arst_address", 32'(o_address), 0);
    chk("arst_en", 32'(o_en), 0);
    chk("arst_we", 32'(o_we), 0);
    chk("arst_data", 32'(o_data), 0);
    chk("arst_done", 32'(o_done), 0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("arst_first_kept", 32'(mem[512]), 32'hB8);
    chk("arst_513_unwritten", 32'(mem[513]), 32'hEE);
    @(negedge clk);
    chk("arst_no_restart", 32'(o_en), 0);
    run_vec(vecs[0], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
